div_sequencer: RTL and testbench
================================

// Module: div_sequencer
//
// PURPOSE
//   Iterative RV32M divide unit with its own sequencing FSM. Executes DIV/DIVU/REM/REMU
//   issued from EXE, one quotient bit per cycle (radix-2 restoring). Drives divide_stall
//   to the pipeline controller, holding IF/ID/EXE/MEM/WB and PC until the result is ready.
//   Sits beside the ALU in EXE; its result muxes into the EXE result path.
//
// PARAMETERS
//   XLEN   32   operand/result width; iteration count = XLEN
//
// PORTS
//   clk           in   1     core clock
//   reset_n       in   1     asynchronous, active-low reset
//   div_start     in   1     level: divide instruction valid in EXE (held while stalled)
//   div_op        in   2     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   div_rs1       in   XLEN  dividend (forwarded operand)
//   div_rs2       in   XLEN  divisor (forwarded operand)
//   div_kill      in   1     flush of EXE (branch_hazard | mret | interrupt | halt)
//   divide_stall  out  1     hold pipeline; to pipeline controller
//   div_valid     out  1     div_result valid this cycle (instruction leaves EXE)
//   div_result    out  XLEN  quotient or remainder per div_op
//
// BEHAVIOUR
//   - Reset: state IDLE, counter 0, all regs 0; div_valid=0, div_result=0,
//     divide_stall=0 while reset_n low regardless of div_start.
//   - States: IDLE, BUSY, DONE.
//   - IDLE: div_start=1 & div_kill=0 -> latch div_op, operand magnitudes, result signs;
//     divide_stall=1 (combinational, same cycle). Next state:
//       * divisor==0 or signed overflow (DIV/REM, rs1=1<<(XLEN-1), rs2=all-ones) -> DONE
//       * otherwise -> BUSY, counter=XLEN.
//   - BUSY: divide_stall=1; each cycle shift {rem,quo} left 1, trial-subtract divisor,
//     set quotient LSB on non-negative; counter decrements; counter hits 0 -> DONE.
//   - DONE: divide_stall=0, div_valid=1, div_result registered-stable this cycle;
//     next state IDLE unconditionally. div_start still high in DONE is the same
//     instruction and must not retrigger.
//   - Latency: normal op = XLEN+1 stall cycles (IDLE accept + XLEN BUSY), result in
//     DONE cycle. Shortcut ops = 1 stall cycle.
//   - Sign rules (signed ops): divide magnitudes; quotient negated if sign(rs1)^sign(rs2);
//     remainder takes sign of rs1. Unsigned ops use raw operands.
//   - Divide by zero: quotient = all-ones (all op types), remainder = rs1.
//   - Signed overflow: quotient = rs1 (1<<(XLEN-1)), remainder = 0.
//   - div_kill: highest priority in every state; divide_stall=0 and div_valid=0 that
//     cycle; next state IDLE; counter cleared. No result produced for killed op.
//   - div_kill with div_start in IDLE: no accept, stay IDLE.
//   - Back-to-back: IDLE after DONE accepts a new div_start the following cycle.
//   - Operands sampled only at IDLE accept; later changes on div_rs1/div_rs2 ignored.
//   - div_result holds last value outside DONE; consumers qualify with div_valid.
//   - Async reset mid-BUSY: immediate return to IDLE, outputs to reset values.
//
// TESTING
//   1. DIVU 100/7: div_start held -> divide_stall high 33 cycles, then div_valid=1,
//      div_result=14; REMU same operands -> 2.
//   2. REM -7,2 -> 0xFFFFFFFF; DIV -7,2 -> 0xFFFFFFFD; DIV 7,-2 -> 0xFFFFFFFD.
//   3. DIV 5/0 -> one stall cycle, div_result=0xFFFFFFFF; REM 5/0 -> 5.
//   4. DIV 0x80000000/0xFFFFFFFF -> 1 stall cycle, 0x80000000; REM -> 0.
//   5. div_kill at BUSY counter=10 -> divide_stall=0 same cycle, no div_valid, IDLE next;
//      new DIVU 9/3 then completes with 3 after 33 stall cycles.
//   6. reset_n low mid-BUSY with div_start=1 -> divide_stall=0, div_valid=0 immediately;
//      after release, held div_start restarts operation from IDLE.

Source files
------------

// File: rtl/div_if.sv
// Handshake bundle between the EXE stage and the iterative divider.
// The master is the EXE stage (issue side) and the slave is the divide unit.
interface div_if #(
  parameter int XLEN = 32
);
  logic            div_start;
  logic [1:0]      div_op;
  logic [XLEN-1:0] div_rs1;
  logic [XLEN-1:0] div_rs2;
  logic            div_kill;
  logic            divide_stall;
  logic            div_valid;
  logic [XLEN-1:0] div_result;

  modport master (
    output div_start, div_op, div_rs1, div_rs2, div_kill,
    input  divide_stall, div_valid, div_result
  );

  modport slave (
    input  div_start, div_op, div_rs1, div_rs2, div_kill,
    output divide_stall, div_valid, div_result
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU).
// Produces one quotient bit per cycle and stalls the pipeline until the result is ready.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic reset_n,
  div_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;

  logic            signed_op_s;
  logic            rs1_neg_s;
  logic            rs2_neg_s;
  logic [XLEN-1:0] rs1_mag_s;
  logic [XLEN-1:0] rs2_mag_s;
  logic            div_zero_s;
  logic            overflow_s;
  logic [XLEN:0]   shifted_s;
  logic            ge_s;
  logic [XLEN-1:0] rem_next_s;
  logic [XLEN-1:0] quo_next_s;
  logic [XLEN-1:0] final_s;

  // Operand decode and one restoring-division step
  always_comb begin
    signed_op_s = ~bus.div_op[0];
    rs1_neg_s   = signed_op_s & bus.div_rs1[XLEN-1];
    rs2_neg_s   = signed_op_s & bus.div_rs2[XLEN-1];
    rs1_mag_s   = rs1_neg_s ? ({XLEN{1'b0}} - bus.div_rs1) : bus.div_rs1;
    rs2_mag_s   = rs2_neg_s ? ({XLEN{1'b0}} - bus.div_rs2) : bus.div_rs2;
    div_zero_s  = (bus.div_rs2 == {XLEN{1'b0}});
    overflow_s  = signed_op_s
                & (bus.div_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                & (bus.div_rs2 == {XLEN{1'b1}});

    // Shifted partial remainder needs one extra bit: it can reach 2*divisor-1
    shifted_s  = {rem_q, quo_q[XLEN-1]};
    ge_s       = (shifted_s >= {1'b0, dvs_q});
    rem_next_s = ge_s ? (shifted_s[XLEN-1:0] - dvs_q) : shifted_s[XLEN-1:0];
    quo_next_s = {quo_q[XLEN-2:0], ge_s};

    if (is_rem_q) begin
      final_s = neg_rem_q ? ({XLEN{1'b0}} - rem_next_s) : rem_next_s;
    end else begin
      final_s = neg_quo_q ? ({XLEN{1'b0}} - quo_next_s) : quo_next_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      IDLE: begin
        if (bus.div_kill) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else if (bus.div_start) begin
          is_rem_d  = bus.div_op[1];
          neg_quo_d = rs1_neg_s ^ rs2_neg_s;
          neg_rem_d = rs1_neg_s;
          quo_d     = rs1_mag_s;
          rem_d     = {XLEN{1'b0}};
          dvs_d     = rs2_mag_s;
          // Corner cases bypass iteration and finish in the DONE cycle
          if (div_zero_s) begin
            result_d = bus.div_op[1] ? bus.div_rs1 : {XLEN{1'b1}};
            state_d  = DONE;
          end else if (overflow_s) begin
            result_d = bus.div_op[1] ? {XLEN{1'b0}} : bus.div_rs1;
            state_d  = DONE;
          end else begin
            cnt_d   = CW'(XLEN);
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.div_kill) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          quo_d = quo_next_s;
          rem_d = rem_next_s;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = final_s;
            state_d  = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      quo_q     <= {XLEN{1'b0}};
      rem_q     <= {XLEN{1'b0}};
      dvs_q     <= {XLEN{1'b0}};
      result_q  <= {XLEN{1'b0}};
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Stall must rise in the accept cycle and drop immediately on kill or reset
  always_comb begin
    bus.divide_stall = reset_n & ~bus.div_kill
                     & (((state_q == IDLE) & bus.div_start) | (state_q == BUSY));
    bus.div_valid    = reset_n & ~bus.div_kill & (state_q == DONE);
    bus.div_result   = result_q;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: vector table, scoreboard queue and
// hand-written kill/reset sequences.
module tb_div_sequencer;

  localparam int XLEN = 32;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  logic [XLEN-1:0] sb[$];

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              stalls;
  } vec_t;

  vec_t vecs[$];

  div_if #(.XLEN(XLEN)) bus ();

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered just after a posedge; returns just after the posedge that leaves DONE.
  task automatic do_op(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_stalls);
    int stalls;
    bit got;
    logic [XLEN-1:0] want;
    stalls = 0;
    got    = 1'b0;
    bus.div_op    = op;
    bus.div_rs1   = a;
    bus.div_rs2   = b;
    bus.div_start = 1'b1;
    sb.push_back(exp);
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (bus.div_valid) begin
        got = 1'b1;
        check({name, " stall_at_valid"}, {31'd0, bus.divide_stall}, 32'd0);
        if (sb.size() > 0) begin
          want = sb.pop_front();
          check({name, " result"}, bus.div_result, want);
        end else begin
          check({name, " scoreboard_empty"}, 32'd1, 32'd0);
        end
      end else if (bus.divide_stall) begin
        stalls++;
      end
      @(posedge clk);
      #1;
      // Operands are only sampled at accept; scramble them afterwards
      if (c == 0 && exp_stalls > 1) begin
        bus.div_rs1 = $urandom;
        bus.div_rs2 = $urandom;
      end
    end
    bus.div_start = 1'b0;
    if (!got) begin
      check({name, " timeout"}, 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    check({name, " stall_cycles"}, stalls, exp_stalls);
  endtask

  initial begin
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    checks = 0;
    errors = 0;

    vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
    vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          33});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  33});
    vecs.push_back('{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b10, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b11, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
    vecs.push_back('{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  33});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
    vecs.push_back('{2'b01, 32'd3,          32'd10,         32'd0,          33});
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 65535);
      vecs.push_back('{2'b01, ra, rb, ra / rb, 33});
      vecs.push_back('{2'b11, ra, rb, ra % rb, 33});
    end

    // Reset with div_start high: outputs must stay quiet
    reset_n       = 1'b0;
    bus.div_start = 1'b1;
    bus.div_kill  = 1'b0;
    bus.div_op    = 2'b01;
    bus.div_rs1   = 32'd100;
    bus.div_rs2   = 32'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall",  {31'd0, bus.divide_stall}, 32'd0);
    check("reset valid",  {31'd0, bus.div_valid},    32'd0);
    check("reset result", bus.div_result,            32'd0);
    bus.div_start = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table of back-to-back operations
    for (int i = 0; i < vecs.size(); i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stalls);
    end

    // Kill together with start in IDLE: nothing accepted
    bus.div_op    = 2'b01;
    bus.div_rs1   = 32'd50;
    bus.div_rs2   = 32'd5;
    bus.div_start = 1'b1;
    bus.div_kill  = 1'b1;
    @(negedge clk);
    check("idle_kill stall", {31'd0, bus.divide_stall}, 32'd0);
    @(posedge clk);
    #1;
    bus.div_kill  = 1'b0;
    bus.div_start = 1'b0;
    @(negedge clk);
    check("idle_kill stays_idle", {30'd0, bus.divide_stall, bus.div_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Kill in BUSY when counter reaches 10
    bus.div_op    = 2'b01;
    bus.div_rs1   = 32'd1000;
    bus.div_rs2   = 32'd7;
    bus.div_start = 1'b1;
    @(posedge clk);
    repeat (22) @(posedge clk);
    #1;
    bus.div_kill = 1'b1;
    #1;
    check("busy_kill stall", {31'd0, bus.divide_stall}, 32'd0);
    check("busy_kill valid", {31'd0, bus.div_valid},    32'd0);
    @(posedge clk);
    #1;
    bus.div_kill  = 1'b0;
    bus.div_start = 1'b0;
    @(negedge clk);
    check("busy_kill idle", {30'd0, bus.divide_stall, bus.div_valid}, 32'd0);
    @(posedge clk);
    #1;
    do_op("after_kill", 2'b01, 32'd9, 32'd3, 32'd3, 33);

    // Asynchronous reset mid-BUSY with div_start held
    bus.div_op    = 2'b01;
    bus.div_rs1   = 32'd100;
    bus.div_rs2   = 32'd7;
    bus.div_start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_reset stall",  {31'd0, bus.divide_stall}, 32'd0);
    check("mid_reset valid",  {31'd0, bus.div_valid},    32'd0);
    check("mid_reset result", bus.div_result,            32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_op("after_reset", 2'b01, 32'd100, 32'd7, 32'd14, 33);

    @(negedge clk);
    check("final valid_low", {31'd0, bus.div_valid}, 32'd0);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
